// File: rtl/banco_r_seq_if.sv
// Command handshake between the instruction decoder and the register-bank sequencer.
interface banco_r_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_src1;
  logic [2:0] cmd_src2;
  logic [2:0] cmd_dst;
  logic [7:0] cmd_imm;

  // Decoder side: presents commands, observes ready.
  modport master (
    output cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst, cmd_imm,
    input  cmd_ready
  );

  // Sequencer side: consumes commands, drives ready.
  modport slave (
    input  cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst, cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/banco_r_seq.sv
// Command sequencer for the 8x8-bit register bank: reads operands, computes, writes back.
module banco_r_seq (
  input  logic                 clk,
  input  logic                 reset,
  banco_r_seq_if.slave         cmd,
  output logic [2:0]           AddrR1,
  output logic [2:0]           AddrR2,
  output logic [2:0]           AddrW,
  output logic [7:0]           DataIn,
  output logic                 W_R,
  input  logic [7:0]           RX,
  input  logic [7:0]           RY,
  output logic [7:0]           result,
  output logic                 carry,
  output logic                 zero,
  output logic                 done
);

  localparam int unsigned DW = 8;

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_CAPT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [DW-1:0]   alu_res;
  logic            alu_carry;
  logic [DW:0]     sum;

  // Reset gates ready and write enable so an abort drops W_R in the same cycle.
  assign cmd.cmd_ready = (state == S_IDLE) && reset;
  assign W_R           = (state == S_WRITE) && reset;
  assign DataIn        = result;

  // Datapath: result and carry for the latched op from the captured operands.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sum       = (DW+1)'(RX) + (DW+1)'(RY);
    case (op_q)
      OP_MOV: alu_res = RX;
      OP_ADD: begin
        alu_res   = sum[DW-1:0];
        alu_carry = sum[DW];
      end
      OP_SUB, OP_CMP: begin
        alu_res   = RX - RY;
        alu_carry = (RX < RY);
      end
      OP_AND: alu_res = RX & RY;
      OP_OR:  alu_res = RX | RY;
      OP_XOR: alu_res = RX ^ RY;
      default: alu_res = '0;
    endcase
  end

  // Sequencer FSM with registered addresses, result, flags and done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      op_q   <= OP_MOV;
      AddrR1 <= '0;
      AddrR2 <= '0;
      AddrW  <= '0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            op_q   <= cmd.cmd_op;
            AddrR1 <= cmd.cmd_src1;
            AddrR2 <= cmd.cmd_src2;
            AddrW  <= cmd.cmd_dst;
            if (cmd.cmd_op == OP_LDI) begin
              result <= cmd.cmd_imm;
              carry  <= 1'b0;
              zero   <= (cmd.cmd_imm == '0);
              state  <= S_WRITE;
            end else begin
              state <= S_ADDR;
            end
          end
        end
        S_ADDR: state <= S_CAPT;
        S_CAPT: begin
          // Bank data has had a full cycle to settle against the held addresses.
          result <= alu_res;
          carry  <= alu_carry;
          zero   <= (alu_res == '0);
          if (op_q == OP_CMP) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_banco_r_seq.sv
// Randomized self-checking bench for banco_r_seq with a behavioural register bank attached.
module tb_banco_r_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] AddrR1, AddrR2, AddrW;
  logic [7:0] DataIn, RX, RY, result;
  logic       W_R, carry, zero, done;

  int n_checks = 0;
  int n_fail   = 0;

  int ref_reg [8];
  int ref_res, ref_c, ref_z;

  logic [7:0] bank [8];

  always #5 clk = ~clk;

  banco_r_seq_if cmd ();

  banco_r_seq dut (
    .clk    (clk),
    .reset  (reset),
    .cmd    (cmd),
    .AddrR1 (AddrR1),
    .AddrR2 (AddrR2),
    .AddrW  (AddrW),
    .DataIn (DataIn),
    .W_R    (W_R),
    .RX     (RX),
    .RY     (RY),
    .result (result),
    .carry  (carry),
    .zero   (zero),
    .done   (done)
  );

  // Bank model: registered write, combinational read.
  always @(posedge clk) if (W_R) bank[AddrW] <= DataIn;
  assign RX = bank[AddrR1];
  assign RY = bank[AddrR2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference semantics of one command on the architectural register file.
  task automatic model_exec(input int op, input int s1, input int s2, input int imm,
                            output int r, output int c, output bit wr);
    int a, b;
    a  = ref_reg[s1];
    b  = ref_reg[s2];
    c  = 0;
    wr = (op != 7);
    case (op)
      0: r = a;
      1: begin r = (a + b) % 256; c = ((a + b) > 255) ? 1 : 0; end
      2, 7: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      default: r = imm;
    endcase
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one command, watch it to completion, compare against the model.
  task automatic issue(input int op, input int s1, input int s2, input int d,
                       input int imm, input bit busy);
    int er, ec, exp_w, exp_d;
    int wcnt, wcyc, waddr, wdata, dcnt, dcyc, rcyc;
    bit ewr;
    wait_ready();
    model_exec(op, s1, s2, imm, er, ec, ewr);
    exp_w = (op == 6) ? 1 : 3;
    exp_d = (op == 6) ? 2 : ((op == 7) ? 3 : 4);
    cmd.cmd_op    = 3'(op);
    cmd.cmd_src1  = 3'(s1);
    cmd.cmd_src2  = 3'(s2);
    cmd.cmd_dst   = 3'(d);
    cmd.cmd_imm   = 8'(imm);
    cmd.cmd_valid = 1'b1;
    @(posedge clk); #1;
    if (!busy) cmd.cmd_valid = 1'b0;
    wcnt = 0; wcyc = 0; waddr = 0; wdata = 0; dcnt = 0; dcyc = 0; rcyc = 0;
    for (int k = 1; k <= 8; k++) begin
      if (W_R) begin
        wcnt++; wcyc = k; waddr = int'(AddrW); wdata = int'(DataIn);
      end
      if (done) begin
        dcnt++; dcyc = k;
      end
      if (cmd.cmd_ready) begin
        rcyc = k;
        break;
      end
      if (busy) begin
        cmd.cmd_op   = 3'($urandom);
        cmd.cmd_src1 = 3'($urandom);
        cmd.cmd_src2 = 3'($urandom);
        cmd.cmd_dst  = 3'($urandom);
        cmd.cmd_imm  = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    cmd.cmd_valid = 1'b0;
    check("ready_cycle", 32'(rcyc), 32'(exp_d + 1));
    check("wr_count", 32'(wcnt), ewr ? 32'd1 : 32'd0);
    if (ewr) begin
      check("wr_cycle", 32'(wcyc), 32'(exp_w));
      check("wr_addr", 32'(waddr), 32'(d));
      check("wr_data", 32'(wdata), 32'(er));
      ref_reg[d] = er;
    end
    check("done_count", 32'(dcnt), 32'd1);
    check("done_cycle", 32'(dcyc), 32'(exp_d));
    ref_res = er;
    ref_c   = ec;
    ref_z   = (er == 0) ? 1 : 0;
    check("result", 32'(result), 32'(ref_res));
    check("carry", 32'(carry), 32'(ref_c));
    check("zero", 32'(zero), 32'(ref_z));
  endtask

  task automatic check_bank();
    for (int i = 0; i < 8; i++) check("bank_readback", 32'(bank[i]), 32'(ref_reg[i]));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      bank[i]    = 8'h00;
      ref_reg[i] = 0;
    end
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = 3'd0;
    cmd.cmd_src1  = 3'd0;
    cmd.cmd_src2  = 3'd0;
    cmd.cmd_dst   = 3'd0;
    cmd.cmd_imm   = 8'h00;
    reset         = 1'b0;

    // Reset held for two cycles.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_ready", 32'(cmd.cmd_ready), 32'd0);
    check("rst_w_r", 32'(W_R), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_datain", 32'(DataIn), 32'd0);
    check("rst_addrs", 32'({AddrR1, AddrR2, AddrW}), 32'd0);
    check("rst_flags", 32'({carry, zero}), 32'd0);
    reset = 1'b1;
    #1;
    check("ready_after_release", 32'(cmd.cmd_ready), 32'd1);

    // Directed sequence.
    issue(6, 0, 0, 1, 8'hFE, 1'b0);
    issue(6, 0, 0, 2, 8'h03, 1'b0);
    issue(1, 1, 2, 3, 0, 1'b0);
    check("add_const_result", 32'(result), 32'h01);
    check("add_const_carry", 32'(carry), 32'd1);
    issue(2, 2, 1, 4, 0, 1'b0);
    check("sub_const_result", 32'(result), 32'h05);
    issue(7, 1, 1, 6, 0, 1'b0);
    check("cmp_const_zero", 32'(zero), 32'd1);
    issue(1, 3, 1, 6, 0, 1'b1);
    issue(6, 0, 0, 0, 8'h00, 1'b1);
    check_bank();

    // Randomized commands, some with garbage held on the bus while busy.
    for (int n = 0; n < 40; n++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    check_bank();

    // Reset asserted during the WRITE cycle of ADD r5 <- r1 + r2.
    issue(6, 0, 0, 5, 8'hAA, 1'b0);
    issue(6, 0, 0, 1, 8'hFE, 1'b0);
    issue(6, 0, 0, 2, 8'h03, 1'b0);
    wait_ready();
    cmd.cmd_op    = 3'd1;
    cmd.cmd_src1  = 3'd1;
    cmd.cmd_src2  = 3'd2;
    cmd.cmd_dst   = 3'd5;
    cmd.cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd.cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_abort_w_r", 32'(W_R), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_w_r_drop", 32'(W_R), 32'd0);
    @(posedge clk); #1;
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready_low", 32'(cmd.cmd_ready), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_addr_w", 32'(AddrW), 32'd0);
    reset = 1'b1;
    #1;
    check("abort_idle_ready", 32'(cmd.cmd_ready), 32'd1);
    @(posedge clk); #1;
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_r5_kept", 32'(bank[5]), 32'hAA);
    ref_res = 0; ref_c = 0; ref_z = 0;
    issue(1, 1, 2, 5, 0, 1'b0);
    check_bank();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/banco_r_seq.md
# banco_r_seq

Command sequencer driving the 8×8-bit register bank (`Banco_R`) from the initiator side.
- Accepts one register-transfer command per handshake: load-immediate, move, ALU op, or compare.
- For each command it drives the bank's read addresses, captures `RX`/`RY`, computes the result, and writes it back through `AddrW`/`DataIn`/`W_R`.
- Sits between the instruction decoder and the register bank; it is the bank's only writer.

## Interface
Parameters: none (bank geometry fixed at 8 registers × 8 bits).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_op`  in  3  000 MOV, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 LDI, 111 CMP
- `cmd_src1`  in  3  first source register
- `cmd_src2`  in  3  second source register
- `cmd_dst`  in  3  destination register
- `cmd_imm`  in  8  immediate value for LDI
- `AddrR1`  out  3  bank read address 1
- `AddrR2`  out  3  bank read address 2
- `AddrW`  out  3  bank write address
- `DataIn`  out  8  bank write data
- `W_R`  out  1  bank write enable
- `RX`  in  8  bank read data 1
- `RY`  in  8  bank read data 2
- `result`  out  8  last computed value
- `carry`  out  1  carry/borrow flag
- `zero`  out  1  zero flag
- `done`  out  1  one-cycle completion pulse

## Operation
- **States:** IDLE, ADDR, CAPT, WRITE, DONE.
- **Handshake:** `cmd_ready` = (state==IDLE) && `reset`. A command is accepted on a rising edge with `cmd_valid && cmd_ready`.
  - At acceptance, `op`, `src1`, `src2`, `dst` and `imm` are latched.
  - Command inputs are ignored in every other state.
- **Transitions:**
  - IDLE→ADDR on accept. Exception: LDI goes IDLE→WRITE, with `result` ← `imm`.
  - ADDR→CAPT. `AddrR1`/`AddrR2` are loaded at the accept edge and held.
  - CAPT→WRITE for MOV/ALU ops; CAPT→DONE for CMP. The leaving edge loads `result` ← f(`RX`,`RY`) and updates the flags.
  - WRITE→DONE; DONE→IDLE.
- **Bank-side outputs:**
  - `W_R` = (state==WRITE) && `reset`: exactly one cycle per write.
  - `AddrW` is loaded with `dst` at the accept edge; `DataIn` = `result`.
  - CMP never asserts `W_R`.
  - Addresses hold their last value while IDLE.
- **Arithmetic (operands a=`RX`, b=`RY`):**
  - ADD: 9-bit sum; `result`=sum[7:0], `carry`=sum[8].
  - SUB/CMP: `result`=(a−b) mod 256, `carry`=1 iff a<b (borrow).
  - AND/OR/XOR/MOV (MOV result = a): `carry`=0.
  - `zero`=(`result`==0) for all ops.
  - LDI: flags updated from `imm`, `carry`=0.
- `dst` equal to `src1`/`src2` needs no special handling: capture precedes write.
- **Reset (`reset`=0 at an edge):**
  - State IDLE; all outputs 0 (`AddrR1`, `AddrR2`, `AddrW`, `DataIn`, `W_R`, `result`, `carry`, `zero`, `done`).
  - `cmd_ready`=0 while `reset` is low.
- **Reset mid-operation:** the command is aborted with no write and no `done`. `W_R` drops combinationally in the same cycle `reset` goes low.

## Timing
- Accept edge = E0.
- **MOV/ALU:**
  - ADDR in cycle 1, CAPT in cycle 2.
  - WRITE (`W_R`=1) in cycle 3.
  - `done`=1 in cycle 4; `cmd_ready`=1 again in cycle 5.
- **LDI:** WRITE in cycle 1, `done` in cycle 2, ready in cycle 3.
- **CMP:** ADDR 1, CAPT 2, `done` 3, ready 4.
- **Bank read timing:** `RX`/`RY` are sampled at the end of CAPT, one full cycle after addresses are driven. This works with both combinational-read and one-cycle-registered-read banks.
- `result`/flags are valid from the cycle after the CAPT edge (LDI: from cycle 1) and hold until the next update or reset.
- `done` is high for exactly one cycle per completed command.
- Back-to-back commands: maximum throughput is one ALU command per 5 cycles.

## Test plan
Run with a `Banco_R` instance attached.
1. **Reset:** `reset`=0 for 2 cycles → all outputs 0 and `cmd_ready`=0. Release → `cmd_ready`=1 in the first cycle after release.
2. **LDI:** LDI r1←0xFE, then LDI r2←0x03.
   - `W_R` high exactly one cycle with `AddrW`=1, `DataIn`=0xFE (then `AddrW`=2, `DataIn`=0x03).
   - `done` two cycles after each accept.
   - Bank readback holds the written values.
3. **ADD:** r3←r1+r2 → `result`=0x01, `carry`=1, `zero`=0. `W_R` in cycle 3 with `AddrW`=3; `done` in cycle 4; r3 reads 0x01.
4. **SUB and CMP:**
   - SUB r4←r2−r1 → 0x05, `carry`=1.
   - CMP r1,r1 → `result`=0x00, `zero`=1, `carry`=0; `W_R` stays 0 throughout; `done` in cycle 3.
5. **Busy handling:** hold `cmd_valid`=1 with changing fields while busy → fields are ignored. The next accept happens only when `cmd_ready`=1 and executes the fields present at that edge.
6. **Reset mid-write:** drive `reset`=0 in the WRITE cycle of ADD r5←r1+r2 → `W_R`=0 that cycle, no `done`, state IDLE. Bank r5 is not written by the sequencer.
